// File: rtl/bus_pkg.sv
// Shared definitions for the bus read path.
//   N_SRC / W / SEL_W : number of bus sources, data width, encoded index width
//   bus_rd_state_t    : read controller state encoding
//   R0..R15, HI, LO, ZHI, ZLO, PC, MDR, INPORT, C : bus source indices
package bus_pkg;

    localparam int N_SRC = 24;
    localparam int W     = 32;
    localparam int SEL_W = 5;

    typedef enum logic [1:0] {
        BUS_IDLE    = 2'd0,
        BUS_CAPTURE = 2'd1,
        BUS_DRIVE   = 2'd2,
        BUS_ERR     = 2'd3
    } bus_rd_state_t;

    localparam int R0     = 0;
    localparam int R1     = 1;
    localparam int R2     = 2;
    localparam int R3     = 3;
    localparam int R4     = 4;
    localparam int R5     = 5;
    localparam int R6     = 6;
    localparam int R7     = 7;
    localparam int R8     = 8;
    localparam int R9     = 9;
    localparam int R10    = 10;
    localparam int R11    = 11;
    localparam int R12    = 12;
    localparam int R13    = 13;
    localparam int R14    = 14;
    localparam int R15    = 15;
    localparam int HI     = 16;
    localparam int LO     = 17;
    localparam int ZHI    = 18;
    localparam int ZLO    = 19;
    localparam int PC     = 20;
    localparam int MDR    = 21;
    localparam int INPORT = 22;
    localparam int C      = 23;

endpackage

// File: rtl/encoder_24to5.sv
// Combinational select encoder for the bus read path.
//   sel : N-bit select vector (one-hot expected)
//   idx : index of the lowest set bit (0 when sel is all zero)
//   any : at least one bit of sel is set
//   one : exactly one bit of sel is set
module encoder_24to5 #(
    parameter int N  = 24,
    parameter int IW = 5
) (
    input  logic [N-1:0]  sel,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          one
);

    // Scan from the top down so the lowest set bit is the last to assign.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sel[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign any = |sel;
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign one = any && ((sel & (sel - N'(1))) == '0);

endmodule

// File: rtl/bus_read_ctrl.sv
// Bus read controller: captures one of N_SRC register outputs selected by a
// one-hot select and holds it on the bus until the consumer acknowledges.
//   clk       : rising-edge clock
//   clr       : synchronous active-low reset
//   src_data  : flattened sources, source i at [i*W +: W]
//   rd_valid  : request valid          rd_sel  : one-hot source select
//   rd_ready  : controller idle, request can be accepted
//   bus_q     : captured value         bus_idx : encoded index of the source
//   bus_valid : bus_q/bus_idx valid    bus_ack : consumer took bus_q
//   err       : one-cycle pulse on an illegal select
// Build option: BUS_ONEHOT_CHECK_EN -- when defined, zero-hot and multi-hot
// selects are rejected via err; otherwise every select is accepted (lowest
// set bit wins, all-zero reads as 0) and err is tied low.
module bus_read_ctrl #(
    parameter int N_SRC = bus_pkg::N_SRC,
    parameter int W     = bus_pkg::W,
    parameter int SEL_W = bus_pkg::SEL_W
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [N_SRC*W-1:0] src_data,
    input  logic               rd_valid,
    input  logic [N_SRC-1:0]   rd_sel,
    output logic               rd_ready,
    output logic [W-1:0]       bus_q,
    output logic [SEL_W-1:0]   bus_idx,
    output logic               bus_valid,
    input  logic               bus_ack,
    output logic               err
);

    import bus_pkg::*;

    localparam logic [1:0] ST_IDLE    = BUS_IDLE;
    localparam logic [1:0] ST_CAPTURE = BUS_CAPTURE;
    localparam logic [1:0] ST_DRIVE   = BUS_DRIVE;
    localparam logic [1:0] ST_ERR     = BUS_ERR;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [N_SRC-1:0] sel_q_reg;
    logic [W-1:0]     bus_q_reg;
    logic [SEL_W-1:0] bus_idx_reg;

    logic [W-1:0]     src_arr [N_SRC];
    logic [N_SRC-1:0] enc_in;
    logic [SEL_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_one;
    logic             sel_legal;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign src_arr[gi] = src_data[gi*W +: W];
        end
    endgenerate

    // One encoder serves both phases: in IDLE it judges the incoming
    // select for legality, in CAPTURE it indexes the latched select.
    assign enc_in = (state_reg == ST_IDLE) ? rd_sel : sel_q_reg;

    encoder_24to5 #(
        .N  (N_SRC),
        .IW (SEL_W)
    ) u_enc (
        .sel (enc_in),
        .idx (enc_idx),
        .any (enc_any),
        .one (enc_one)
    );

`ifdef BUS_ONEHOT_CHECK_EN
    assign sel_legal = enc_one;
    assign err       = (state_reg == ST_ERR);
`else
    logic unused_enc_one;
    assign unused_enc_one = enc_one;
    assign sel_legal      = 1'b1;
    assign err            = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rd_valid) begin
                    state_next = sel_legal ? ST_CAPTURE : ST_ERR;
                end
            end
            ST_CAPTURE: state_next = ST_DRIVE;
            ST_DRIVE: begin
                if (bus_ack) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg   <= ST_IDLE;
            sel_q_reg   <= '0;
            bus_q_reg   <= '0;
            bus_idx_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && rd_valid) begin
                sel_q_reg <= rd_sel;
            end
            // Source data is sampled at the end of CAPTURE, not at request time.
            if (state_reg == ST_CAPTURE) begin
                bus_q_reg   <= enc_any ? src_arr[enc_idx] : '0;
                bus_idx_reg <= enc_idx;
            end
        end
    end

    assign rd_ready  = (state_reg == ST_IDLE);
    assign bus_valid = (state_reg == ST_DRIVE);
    assign bus_q     = bus_q_reg;
    assign bus_idx   = bus_idx_reg;

endmodule
